// File: rtl/mem_bus_ctrl.sv
// Single-word external SRAM access controller: IDLE -> ACCESS -> DONE strobe/ready handshake
// with a minimum wait-state count and an access timeout; all outputs registered.
module mem_bus_ctrl #(
    parameter int MIN_WAIT = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Req,
    input  logic        Write,
    input  logic [15:0] SysBus,
    input  logic [15:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] DataIn,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    input  logic [15:0] MemRData,
    output logic        nME,
    output logic        nOE,
    output logic        nWE,
    input  logic        Ready
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_write;
    logic          w_min_ok;
    logic          w_rdy_ok;
    logic          w_timeout;

    // With no wait states the count check is always satisfied; avoid a vacuous compare.
    generate
        if (MIN_WAIT == 0) begin : g_nowait
            assign w_min_ok = 1'b1;
        end else begin : g_wait
            assign w_min_ok = (r_cnt >= CW'(MIN_WAIT));
        end
    endgenerate

    assign w_rdy_ok  = Ready && w_min_ok;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
            DataIn   <= 16'h0000;
            MemAddr  <= 16'h0000;
            MemWData <= 16'h0000;
            nME      <= 1'b1;
            nOE      <= 1'b1;
            nWE      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Req) begin
                        r_state  <= S_ACCESS;
                        r_cnt    <= '0;
                        r_write  <= Write;
                        MemAddr  <= SysBus;
                        MemWData <= WData;
                        Busy     <= 1'b1;
                        nME      <= 1'b0;
                        nOE      <= Write;
                        nWE      <= !Write;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + CW'(1);
                    // A valid Ready on the timeout edge still completes successfully.
                    if (w_rdy_ok || w_timeout) begin
                        if (w_rdy_ok && !r_write)
                            DataIn <= MemRData;
                        r_state <= S_DONE;
                        Done    <= 1'b1;
                        Error   <= !w_rdy_ok;
                        nME     <= 1'b1;
                        nOE     <= 1'b1;
                        nWE     <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    Error   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
